// File: rtl/grab_obj_pkg.sv
// Shared types and tables for the grabbable-object manager: object types,
// score/weight lookup, colour key and LFSR constants.
package grab_obj_pkg;

  typedef enum logic [3:0] {
    FILLER     = 4'd0,
    VALUABLE_1 = 4'd1,
    VALUABLE_2 = 4'd2,
    VALUABLE_3 = 4'd3,
    ROCK_1     = 4'd4
  } obj_type_e;

  localparam int unsigned SCORE_W  = 10;
  localparam int unsigned WEIGHT_W = 2;

  localparam logic [SCORE_W-1:0]  SCORE_TABLE  [5] = '{10'd0, 10'd50, 10'd100, 10'd250, 10'd10};
  localparam logic [WEIGHT_W-1:0] WEIGHT_TABLE [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

  localparam logic [7:0]  TRANSPARENT       = 8'hFF;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;

  // Map the three low LFSR bits onto the spawn type distribution.
  function automatic obj_type_e type_from_lfsr(input logic [2:0] bits);
    case (bits)
      3'd0, 3'd1, 3'd2: return VALUABLE_1;
      3'd3, 3'd4:       return VALUABLE_2;
      3'd5:             return VALUABLE_3;
      default:          return ROCK_1;
    endcase
  endfunction

  function automatic logic [SCORE_W-1:0] score_of(input obj_type_e t);
    if (t > ROCK_1) return '0;
    return SCORE_TABLE[3'(t)];
  endfunction

  function automatic logic [WEIGHT_W-1:0] weight_of(input obj_type_e t);
    if (t > ROCK_1) return '0;
    return WEIGHT_TABLE[3'(t)];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with seed load and single-step enable; a zero seed
// would lock up, so it is replaced by the default seed.
module lfsr16
  import grab_obj_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_DEFAULT_SEED;
    end else if (load_i) begin
      lfsr_q <= (seed_i == 16'd0) ? LFSR_DEFAULT_SEED : seed_i;
    end else if (step_i) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'd0);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/grab_object_manager.sv
// Object table for the playfield: spawns a level from an LFSR, merges the
// renderer outputs, and tracks grab/reel/retire of one object at a time.
module grab_object_manager
  import grab_obj_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned FIELD_X0  = 64,
  parameter int unsigned FIELD_Y0  = 192,
  parameter int unsigned OBJ_SIZE  = 32
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic                            levelStart,
  input  logic [15:0]                     levelSeed,
  input  logic [10:0]                     hookX,
  input  logic [10:0]                     hookY,
  input  logic                            hookDR,
  input  logic                            hookHome,
  input  logic [NUM_SLOTS-1:0]            objDR,
  input  logic [NUM_SLOTS-1:0][7:0]       objRGB,
  output logic [NUM_SLOTS-1:0][10:0]      objTopLeftX,
  output logic [NUM_SLOTS-1:0][10:0]      objTopLeftY,
  output logic [NUM_SLOTS-1:0][3:0]       objType,
  output logic                            drawReq,
  output logic [7:0]                      RGBout,
  output logic                            grabValid,
  output logic [WEIGHT_W-1:0]             grabWeight,
  output logic                            scoreValid,
  output logic [SCORE_W-1:0]              scoreValue,
  output logic                            levelDone
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
  localparam int unsigned HALF  = OBJ_SIZE / 2;

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_ACTIVE, S_GRABBED, S_RETIRE} state_e;

  state_e                       state_q;
  logic [IDX_W-1:0]             spawn_idx_q;
  logic [IDX_W-1:0]             grab_idx_q;
  obj_type_e [NUM_SLOTS-1:0]    type_q;
  logic [NUM_SLOTS-1:0][10:0]   x_q;
  logic [NUM_SLOTS-1:0][10:0]   y_q;
  logic                         grab_valid_q;
  logic [WEIGHT_W-1:0]          grab_weight_q;
  logic                         score_valid_q;
  logic [SCORE_W-1:0]           score_value_q;
  logic                         level_done_q;

  logic [15:0]                  lfsr_val;
  logic                         unused_lfsr_bits;
  logic [NUM_SLOTS-1:0]         nonfill;
  logic [NUM_SLOTS-1:0]         grab_onehot;
  logic                         hit_valid;
  logic [IDX_W-1:0]             hit_idx;
  obj_type_e                    spawn_type;
  logic [10:0]                  spawn_x;
  logic [10:0]                  spawn_y;
  logic [10:0]                  attach_x;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (resetN),
    .load_i  (levelStart),
    .seed_i  (levelSeed),
    .step_i  (state_q == S_SPAWN),
    .value_o (lfsr_val)
  );

  assign unused_lfsr_bits = ^lfsr_val[5:3];
  assign spawn_type = type_from_lfsr(lfsr_val[2:0]);
  assign spawn_x    = 11'(FIELD_X0) + 11'(lfsr_val[14:6]);
  assign spawn_y    = 11'(FIELD_Y0) + 11'({lfsr_val[15], lfsr_val[12:6]});
  assign attach_x   = (hookX < 11'(HALF)) ? 11'd0 : hookX - 11'(HALF);
  assign grab_onehot = NUM_SLOTS'(1) << grab_idx_q;

  // Lowest-index colliding live object; iterating downward leaves the lowest.
  always_comb begin
    nonfill   = '0;
    hit_valid = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      nonfill[i] = (type_q[i] != FILLER);
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hookDR && objDR[i] && nonfill[i]) begin
        hit_valid = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  // Renderer merge: index 0 is drawn on top.
  always_comb begin
    drawReq = |objDR;
    RGBout  = TRANSPARENT;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (objDR[i]) RGBout = objRGB[i];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      spawn_idx_q   <= '0;
      grab_idx_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) type_q[i] <= FILLER;
      x_q           <= '0;
      y_q           <= '0;
      grab_valid_q  <= 1'b0;
      grab_weight_q <= '0;
      score_valid_q <= 1'b0;
      score_value_q <= '0;
      level_done_q  <= 1'b0;
    end else begin
      grab_valid_q  <= 1'b0;
      score_valid_q <= 1'b0;
      level_done_q  <= 1'b0;
      if (levelStart) begin
        state_q       <= S_SPAWN;
        spawn_idx_q   <= '0;
        grab_weight_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_SPAWN: begin
            type_q[spawn_idx_q] <= spawn_type;
            x_q[spawn_idx_q]    <= spawn_x;
            y_q[spawn_idx_q]    <= spawn_y;
            spawn_idx_q         <= spawn_idx_q + IDX_W'(1);
            if (spawn_idx_q == IDX_W'(NUM_SLOTS - 1)) state_q <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (hit_valid) begin
              grab_idx_q    <= hit_idx;
              grab_valid_q  <= 1'b1;
              grab_weight_q <= weight_of(type_q[hit_idx]);
              state_q       <= S_GRABBED;
            end
          end
          S_GRABBED: begin
            if (hookHome) begin
              type_q[grab_idx_q] <= FILLER;
              score_valid_q      <= 1'b1;
              score_value_q      <= score_of(type_q[grab_idx_q]);
              grab_weight_q      <= '0;
              level_done_q       <= ((nonfill & ~grab_onehot) == '0);
              state_q            <= S_RETIRE;
            end else if (startOfFrame) begin
              x_q[grab_idx_q] <= attach_x;
              y_q[grab_idx_q] <= hookY;
            end
          end
          S_RETIRE: state_q <= level_done_q ? S_IDLE : S_ACTIVE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign objTopLeftX = x_q;
  assign objTopLeftY = y_q;
  assign objType     = type_q;
  assign grabValid   = grab_valid_q;
  assign grabWeight  = grab_weight_q;
  assign scoreValid  = score_valid_q;
  assign scoreValue  = score_value_q;
  assign levelDone   = level_done_q;

endmodule

// File: tb/tb_grab_object_manager.sv
// Self-checking bench for grab_object_manager: a behavioural playfield model
// compared every cycle, plus directed scenarios with hand-computed values.
module tb_grab_object_manager;

  logic             clk = 1'b0;
  logic             resetN;
  logic             startOfFrame, levelStart, hookDR, hookHome;
  logic [15:0]      levelSeed;
  logic [10:0]      hookX, hookY;
  logic [7:0]       objDR;
  logic [7:0][7:0]  objRGB;
  logic [7:0][10:0] objTopLeftX, objTopLeftY;
  logic [7:0][3:0]  objType;
  logic             drawReq;
  logic [7:0]       RGBout;
  logic             grabValid;
  logic [1:0]       grabWeight;
  logic             scoreValid;
  logic [9:0]       scoreValue;
  logic             levelDone;

  int n_cmp = 0;
  int n_bad = 0;

  grab_object_manager dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .levelStart(levelStart),
    .levelSeed(levelSeed), .hookX(hookX), .hookY(hookY), .hookDR(hookDR),
    .hookHome(hookHome), .objDR(objDR), .objRGB(objRGB), .objTopLeftX(objTopLeftX),
    .objTopLeftY(objTopLeftY), .objType(objType), .drawReq(drawReq), .RGBout(RGBout),
    .grabValid(grabValid), .grabWeight(grabWeight), .scoreValid(scoreValid),
    .scoreValue(scoreValue), .levelDone(levelDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int         m_type [8];
  int         m_x [8];
  int         m_y [8];
  logic [15:0] m_lfsr;
  int         m_spawn;
  bit         m_live, m_hold, m_ret;
  int         m_slot;
  bit         m_gv, m_sv, m_ld;
  int         m_score, m_weight;
  int         type_map   [8] = '{1, 1, 1, 2, 2, 3, 4, 4};
  int         score_tab  [5] = '{0, 50, 100, 250, 10};
  int         weight_tab [5] = '{0, 1, 2, 3, 3};

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int remaining();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_type[i] != 0) n++;
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 8; i++) begin m_type[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_lfsr = 16'hACE1; m_spawn = -1; m_live = 0; m_hold = 0; m_ret = 0; m_slot = 0;
      m_gv = 0; m_sv = 0; m_ld = 0; m_score = 0; m_weight = 0;
    end else begin
      m_gv = 0; m_sv = 0; m_ld = 0;
      if (levelStart) begin
        m_lfsr = (levelSeed == 16'd0) ? 16'hACE1 : levelSeed;
        m_spawn = 0; m_live = 0; m_hold = 0; m_ret = 0; m_weight = 0;
      end else if (m_spawn >= 0) begin
        m_type[m_spawn] = type_map[m_lfsr[2:0]];
        m_x[m_spawn] = 64 + int'(m_lfsr[14:6]);
        m_y[m_spawn] = 192 + int'({m_lfsr[15], m_lfsr[12:6]});
        m_lfsr = lfsr_next(m_lfsr);
        m_spawn++;
        if (m_spawn == 8) begin m_spawn = -1; m_live = 1; end
      end else if (m_ret) begin
        m_ret = 0;
        m_live = (remaining() > 0);
      end else if (m_hold) begin
        if (hookHome) begin
          m_sv = 1; m_score = score_tab[m_type[m_slot]];
          m_type[m_slot] = 0; m_weight = 0; m_hold = 0; m_ret = 1;
          m_ld = (remaining() == 0);
        end else if (startOfFrame) begin
          m_x[m_slot] = (int'(hookX) < 16) ? 0 : int'(hookX) - 16;
          m_y[m_slot] = int'(hookY);
        end
      end else if (m_live && hookDR) begin
        int found = -1;
        for (int i = 7; i >= 0; i--) if (objDR[i] && m_type[i] != 0) found = i;
        if (found >= 0) begin
          m_slot = found; m_hold = 1; m_gv = 1; m_weight = weight_tab[m_type[found]];
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int exp_rgb;
    exp_rgb = 255;
    for (int i = 7; i >= 0; i--) if (objDR[i]) exp_rgb = int'(objRGB[i]);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("objType[%0d]", i), 32'(objType[i]), m_type[i]);
      check($sformatf("objX[%0d]", i), 32'(objTopLeftX[i]), m_x[i]);
      check($sformatf("objY[%0d]", i), 32'(objTopLeftY[i]), m_y[i]);
    end
    check("grabValid", 32'(grabValid), 32'(m_gv));
    check("grabWeight", 32'(grabWeight), m_weight);
    check("scoreValid", 32'(scoreValid), 32'(m_sv));
    check("scoreValue", 32'(scoreValue), m_score);
    check("levelDone", 32'(levelDone), 32'(m_ld));
    check("drawReq", 32'(drawReq), 32'(objDR != 8'd0));
    check("RGBout", 32'(RGBout), exp_rgb);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    resetN = 1'b0; startOfFrame = 0; levelStart = 0; hookDR = 0; hookHome = 0;
    levelSeed = 16'h0; hookX = '0; hookY = '0; objDR = '0;
    for (int i = 0; i < 8; i++) objRGB[i] = 8'(8'h10 + i);
    repeat (3) cyc();
    check("reset_type0", 32'(objType[0]), 0);
    check("reset_score", 32'(scoreValue), 0);
    resetN = 1'b1;
    cyc();

    // Spawn with seed ACE1; slot 7 must appear on the 8th spawn cycle.
    levelSeed = 16'hACE1; levelStart = 1; cyc(); levelStart = 0;
    n = 0;
    while (objType[7] == 4'd0 && n < 20) begin cyc(); n++; end
    check("spawn_len", n, 8);
    check("slot0_type", 32'(objType[0]), 1);
    check("slot0_x", 32'(objTopLeftX[0]), 243);
    check("slot0_y", 32'(objTopLeftY[0]), 371);
    check("slot1_x", 32'(objTopLeftX[1]), 457);
    check("slot1_y", 32'(objTopLeftY[1]), 329);
    check("slot7_x", 32'(objTopLeftX[7]), 502);

    // Two colliding slots: the lower index (2) is attached.
    hookDR = 1; objDR = 8'b0010_0100; #1;
    check("merge_rgb", 32'(RGBout), 32'h12);
    cyc(); hookDR = 0; objDR = '0;
    check("grab_pulse", 32'(grabValid), 1);
    check("grab_weight2", 32'(grabWeight), 1);
    cyc();
    check("grab_pulse_end", 32'(grabValid), 0);

    // Collisions while holding are ignored; position tracks on startOfFrame.
    hookDR = 1; objDR = 8'b0000_0001; cyc(); hookDR = 0; objDR = '0;
    hookX = 11'd300; hookY = 11'd250; startOfFrame = 1; cyc(); startOfFrame = 0;
    check("attach_x", 32'(objTopLeftX[2]), 284);
    check("attach_y", 32'(objTopLeftY[2]), 250);
    hookX = 11'd5; startOfFrame = 1; cyc(); startOfFrame = 0;
    check("attach_x_clamp", 32'(objTopLeftX[2]), 0);
    hookHome = 1; cyc(); hookHome = 0;
    check("score_v1", 32'(scoreValue), 50);
    check("score_pulse", 32'(scoreValid), 1);
    check("slot2_retired", 32'(objType[2]), 0);
    cyc();

    // hookHome while not holding gives nothing.
    hookHome = 1; cyc(); hookHome = 0;
    check("home_idle_noscore", 32'(scoreValid), 0);

    // Attach and startOfFrame together: position holds this cycle.
    hookX = 11'd300; hookY = 11'd250; hookDR = 1; objDR = 8'h80; startOfFrame = 1;
    cyc(); hookDR = 0; objDR = '0; startOfFrame = 0;
    check("attach_sof_grab", 32'(grabValid), 1);
    check("attach_sof_x", 32'(objTopLeftX[7]), 502);
    startOfFrame = 1; cyc(); startOfFrame = 0;
    check("attach_sof_next", 32'(objTopLeftX[7]), 284);

    // levelStart beats hookHome mid-grab: no score, weight clears.
    levelSeed = 16'h0005; levelStart = 1; hookHome = 1; cyc(); levelStart = 0; hookHome = 0;
    check("abort_noscore", 32'(scoreValid), 0);
    check("abort_weight", 32'(grabWeight), 0);
    repeat (8) cyc();
    check("seed5_type0", 32'(objType[0]), 3);
    check("seed5_x0", 32'(objTopLeftX[0]), 64);
    check("seed5_y0", 32'(objTopLeftY[0]), 192);

    hookDR = 1; objDR = 8'h01; cyc(); hookDR = 0; objDR = '0;
    check("v3_weight", 32'(grabWeight), 3);
    hookHome = 1; cyc(); hookHome = 0;
    check("v3_score", 32'(scoreValue), 250);
    check("v3_retired", 32'(objType[0]), 0);
    cyc();

    // Clear the rest of the level; only the last retire flags levelDone.
    for (int i = 1; i < 8; i++) begin
      hookDR = 1; objDR = 8'(1 << i); cyc(); hookDR = 0; objDR = '0;
      hookHome = 1; cyc(); hookHome = 0;
      check($sformatf("levelDone_%0d", i), 32'(levelDone), (i == 7) ? 1 : 0);
      cyc();
    end
    hookDR = 1; objDR = 8'hFF; hookHome = 1; cyc(); hookDR = 0; objDR = '0; hookHome = 0;
    check("idle_nograb", 32'(grabValid), 0);
    cyc();

    // Reset during spawn, then seed 0 falls back to ACE1.
    levelSeed = 16'h0; levelStart = 1; cyc(); levelStart = 0;
    repeat (3) cyc();
    resetN = 1'b0; #1;
    check("midspawn_reset_type", 32'(objType[0]), 0);
    check("midspawn_reset_score", 32'(scoreValid), 0);
    cyc(); resetN = 1'b1; cyc();
    levelSeed = 16'h0; levelStart = 1; cyc(); levelStart = 0;
    repeat (8) cyc();
    check("seed0_x0", 32'(objTopLeftX[0]), 243);
    check("seed0_y0", 32'(objTopLeftY[0]), 371);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
